fifo_ctrl: RTL and testbench

Control half of the board-level FIFO: tracks read/write pointers and occupancy, generates RAM write enable and read/write addresses, and raises full/empty plus sticky overflow/underflow flags. Sits between the debounced KEY read/write strobes and a dual-port RAM datapath, which it sequences. Operates in show-ahead mode: the RAM word at the read address is the head of the queue, and a read pops it.

---
 rtl/fifo_ctrl_if.sv | 42 ++++
 rtl/fifo_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between the key strobes and fifo_ctrl.
// master drives read/write; slave (fifo_ctrl) returns RAM control and status.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  read;
    logic                  write;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output read,
        output write,
        input  wr_en,
        input  w_addr,
        input  r_addr,
        input  empty,
        input  full,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  read,
        input  write,
        output wr_en,
        output w_addr,
        output r_addr,
        output empty,
        output full,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: show-ahead FIFO control for a dual-port RAM of 2^ADDR_WIDTH words.
// Ports: clk, reset (async, active-low), bus (fifo_ctrl_if.slave):
//   read/write requests in; wr_en, w_addr, r_addr, empty, full, count,
//   sticky overflow/underflow out.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   ONE_CNT = 1;
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR = 1;

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // A write while full is still taken when a pop frees the head slot
    // on the same edge.
    always_comb begin
        wr_acc = bus.write & (~full_q | bus.read);
        rd_acc = bus.read & ~empty_q;
    end

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            w_ptr_d = w_ptr_q + ONE_PTR;
        end
        if (rd_acc) begin
            r_ptr_d = r_ptr_q + ONE_PTR;
        end

        unique case (1'b1)
            (wr_acc & ~rd_acc): count_d = count_q + ONE_CNT;
            (rd_acc & ~wr_acc): count_d = count_q - ONE_CNT;
            default:            count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == MAX_CNT);

        if (bus.write & full_q & ~bus.read) begin
            overflow_d = 1'b1;
        end
        if (bus.read & empty_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.wr_en     = wr_acc;
    assign bus.w_addr    = w_ptr_q;
    assign bus.r_addr    = r_ptr_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed scoreboard bench for fifo_ctrl, depth 4.
// Stimulus queues expected results; a monitor checks them mid-cycle.
module tb_fifo_ctrl;
    typedef struct {
        int         idx;
        logic       wr_en;
        logic [1:0] w;
        logic [1:0] r;
        logic [2:0] c;
        logic       ovf;
        logic       udf;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   op_idx;
    bit   pending;
    exp_t q_exp[$];
    exp_t cur;

    fifo_ctrl_if #(.ADDR_WIDTH(2)) bus ();

    fifo_ctrl #(.ADDR_WIDTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " w_addr"}, 32'(bus.w_addr), 0);
        chk({tag, " r_addr"}, 32'(bus.r_addr), 0);
        chk({tag, " count"}, 32'(bus.count), 0);
        chk({tag, " empty"}, 32'(bus.empty), 1);
        chk({tag, " full"}, 32'(bus.full), 0);
        chk({tag, " overflow"}, 32'(bus.overflow), 0);
        chk({tag, " underflow"}, 32'(bus.underflow), 0);
    endtask

    // Monitor: at each negedge first check the state left by the previous
    // edge, then the combinational wr_en of the op now being presented.
    initial begin
        forever begin
            @(negedge clk);
            if (pending) begin
                string t;
                pending = 0;
                t = $sformatf("op%0d", cur.idx);
                chk({t, " w_addr"}, 32'(bus.w_addr), 32'(cur.w));
                chk({t, " r_addr"}, 32'(bus.r_addr), 32'(cur.r));
                chk({t, " count"}, 32'(bus.count), 32'(cur.c));
                chk({t, " empty"}, 32'(bus.empty), 32'(cur.c == 0));
                chk({t, " full"}, 32'(bus.full), 32'(cur.c == 4));
                chk({t, " overflow"}, 32'(bus.overflow), 32'(cur.ovf));
                chk({t, " underflow"}, 32'(bus.underflow), 32'(cur.udf));
            end
            if (q_exp.size() > 0) begin
                cur = q_exp.pop_front();
                chk($sformatf("op%0d wr_en", cur.idx),
                    32'(bus.wr_en), 32'(cur.wr_en));
                pending = 1;
            end
        end
    end

    task automatic op(input logic rd, input logic wr, input logic we,
                      input logic [1:0] w, input logic [1:0] r,
                      input logic [2:0] c, input logic ovf,
                      input logic udf);
        exp_t e;
        @(posedge clk);
        #1;
        bus.read  = rd;
        bus.write = wr;
        op_idx++;
        e.idx   = op_idx;
        e.wr_en = we;
        e.w     = w;
        e.r     = r;
        e.c     = c;
        e.ovf   = ovf;
        e.udf   = udf;
        q_exp.push_back(e);
    endtask

    task automatic idle_drain();
        int n;
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        n = 0;
        while ((q_exp.size() != 0 || pending) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (q_exp.size() != 0 || pending) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
    endtask

    task automatic do_reset(input string tag, input logic hold_wr);
        idle_drain();
        @(negedge clk);
        #2;
        bus.write = hold_wr;
        reset = 1'b0;
        #1;
        chk_reset({tag, " async"});
        if (hold_wr) begin
            @(posedge clk);
            #1;
            chk_reset({tag, " held"});
        end
        @(negedge clk);
        bus.write = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        op_idx    = 0;
        pending   = 0;
        reset     = 1'b1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b1;

        // fill
        op(0, 1, 1, 2'd1, 2'd0, 3'd1, 0, 0);
        op(0, 1, 1, 2'd2, 2'd0, 3'd2, 0, 0);
        op(0, 1, 1, 2'd3, 2'd0, 3'd3, 0, 0);
        op(0, 1, 1, 2'd0, 2'd0, 3'd4, 0, 0);
        // overflow, then drain
        op(0, 1, 0, 2'd0, 2'd0, 3'd4, 1, 0);
        op(1, 0, 0, 2'd0, 2'd1, 3'd3, 1, 0);
        op(1, 0, 0, 2'd0, 2'd2, 3'd2, 1, 0);
        op(1, 0, 0, 2'd0, 2'd3, 3'd1, 1, 0);
        op(1, 0, 0, 2'd0, 2'd0, 3'd0, 1, 0);
        // underflow, then read+write while empty
        op(1, 0, 0, 2'd0, 2'd0, 3'd0, 1, 1);
        op(1, 1, 1, 2'd1, 2'd0, 3'd1, 1, 1);

        do_reset("rst1", 1'b0);
        // simultaneous read+write at full
        op(0, 1, 1, 2'd1, 2'd0, 3'd1, 0, 0);
        op(0, 1, 1, 2'd2, 2'd0, 3'd2, 0, 0);
        op(0, 1, 1, 2'd3, 2'd0, 3'd3, 0, 0);
        op(0, 1, 1, 2'd0, 2'd0, 3'd4, 0, 0);
        op(1, 1, 1, 2'd1, 2'd1, 3'd4, 0, 0);

        do_reset("rst2", 1'b0);
        // wrap with occupancy at most 2
        op(0, 1, 1, 2'd1, 2'd0, 3'd1, 0, 0);
        op(0, 1, 1, 2'd2, 2'd0, 3'd2, 0, 0);
        op(1, 1, 1, 2'd3, 2'd1, 3'd2, 0, 0);
        op(1, 1, 1, 2'd0, 2'd2, 3'd2, 0, 0);
        op(1, 1, 1, 2'd1, 2'd3, 3'd2, 0, 0);
        op(1, 0, 0, 2'd1, 2'd0, 3'd1, 0, 0);
        op(0, 1, 1, 2'd2, 2'd0, 3'd2, 0, 0);
        op(1, 0, 0, 2'd2, 2'd1, 3'd1, 0, 0);
        op(0, 1, 1, 2'd3, 2'd1, 3'd2, 0, 0);

        // mid-operation reset with count=2, write held through an edge
        do_reset("rst3", 1'b1);
        op(0, 1, 1, 2'd1, 2'd0, 3'd1, 0, 0);
        idle_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
